// File: rtl/amber_wb_resp_pkg.sv
// ----------------------------------------------------------------------------
// amber_wb_resp_pkg
// Shared types and constants for the Amber23 Wishbone responder.
//   resp_state_t : responder FSM states
//   AMBER_NOP    : instruction returned when a fetch finds the queue empty
//                  (ARM "mov r0, r0")
//   st_entry_t   : one captured write cycle {adr, sel, dat}
// ----------------------------------------------------------------------------
package amber_wb_resp_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    WAIT  = 2'd1,
    STALL = 2'd2,
    RESP  = 2'd3
  } resp_state_t;

  localparam logic [31:0] AMBER_NOP = 32'hE1A0_0000;

  typedef struct packed {
    logic [31:0] adr;
    logic [3:0]  sel;
    logic [31:0] dat;
  } st_entry_t;

endpackage

// File: rtl/amber_wb_responder_fifo.sv
// ----------------------------------------------------------------------------
// wb_resp_fifo
// Synchronous first-word-fall-through FIFO. Pointers carry one extra wrap bit
// so full and empty are told apart without a separate counter.
// Ports:
//   clk, rst          clock, asynchronous active-high reset (empties the FIFO)
//   push_valid        push request; accepted only while push_ready is high
//   push_ready        !full
//   push_data         word to store
//   pop_req           remove the head entry; ignored while empty
//   head_data         current head entry (undefined while empty)
//   empty             no entries stored
// ----------------------------------------------------------------------------
module wb_resp_fifo #(
  parameter int WIDTH = 32,
  parameter int DEPTH = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             push_valid,
  output logic             push_ready,
  input  logic [WIDTH-1:0] push_data,
  input  logic             pop_req,
  output logic [WIDTH-1:0] head_data,
  output logic             empty
);

  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] PTR_ONE = {{AW{1'b0}}, 1'b1};

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW:0]      wr_ptr_reg;
  logic [AW:0]      rd_ptr_reg;
  logic             full;
  logic             do_push;
  logic             do_pop;

  assign empty      = (wr_ptr_reg == rd_ptr_reg);
  // Same slot index, different lap: writer is a whole lap ahead.
  assign full       = (wr_ptr_reg[AW] != rd_ptr_reg[AW]) &&
                      (wr_ptr_reg[AW-1:0] == rd_ptr_reg[AW-1:0]);
  assign push_ready = !full;
  // Push is judged on the registered full flag, so a simultaneous pop never
  // makes room for a push to a full queue; likewise a pop on empty is dropped
  // even when a push lands in the same cycle.
  assign do_push    = push_valid && !full;
  assign do_pop     = pop_req && !empty;
  assign head_data  = mem[rd_ptr_reg[AW-1:0]];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr_reg <= '0;
      rd_ptr_reg <= '0;
    end else begin
      if (do_push) wr_ptr_reg <= wr_ptr_reg + PTR_ONE;
      if (do_pop)  rd_ptr_reg <= rd_ptr_reg + PTR_ONE;
    end
  end

  // Storage needs no reset: contents are only visible through valid pointers.
  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr_reg[AW-1:0]] <= push_data;
  end

endmodule

// File: rtl/amber_wb_responder.sv
// ----------------------------------------------------------------------------
// amber_wb_responder
// Wishbone B3 classic slave answering the Amber23 core master port. Reads are
// served from an instruction queue (addresses below DATA_BASE) or a load-data
// queue (at or above DATA_BASE); writes are captured into a store queue that
// a monitor drains.
// Ports:
//   i_clk, i_rst                 clock, asynchronous active-high reset
//   i_wb_adr/sel/we/dat/cyc/stb  core master request
//   o_wb_dat/ack/err             response; o_wb_dat valid with ack, held after
//   i_inst_valid/o_inst_ready/i_inst_data   instruction queue push
//   i_ld_valid/o_ld_ready/i_ld_data         load-data queue push
//   o_st_valid/i_st_ready        store queue pop handshake
//   o_st_adr/sel/dat             store queue head entry
//   o_fetch_cnt                  completed instruction fetches (wraps)
// ----------------------------------------------------------------------------
module amber_wb_responder
  import amber_wb_resp_pkg::*;
#(
  parameter int          DEPTH        = 16,
  parameter int          WAIT_CYCLES  = 0,
  parameter logic [31:0] DATA_BASE    = 32'h0000_8000,
  parameter bit          ERR_ON_EMPTY = 1'b1
) (
  input  logic        i_clk,
  input  logic        i_rst,
  input  logic [31:0] i_wb_adr,
  input  logic [3:0]  i_wb_sel,
  input  logic        i_wb_we,
  input  logic [31:0] i_wb_dat,
  input  logic        i_wb_cyc,
  input  logic        i_wb_stb,
  output logic [31:0] o_wb_dat,
  output logic        o_wb_ack,
  output logic        o_wb_err,
  input  logic        i_inst_valid,
  output logic        o_inst_ready,
  input  logic [31:0] i_inst_data,
  input  logic        i_ld_valid,
  output logic        o_ld_ready,
  input  logic [31:0] i_ld_data,
  output logic        o_st_valid,
  input  logic        i_st_ready,
  output logic [31:0] o_st_adr,
  output logic [3:0]  o_st_sel,
  output logic [31:0] o_st_dat,
  output logic [15:0] o_fetch_cnt
);

  // Countdown preload: the first WAIT cycle already counts as one wait state.
  localparam int          WAIT_M1   = (WAIT_CYCLES > 0) ? WAIT_CYCLES - 1 : 0;
  localparam logic [3:0]  WAIT_LOAD = WAIT_M1[3:0];

  resp_state_t state_reg, state_next;
  logic [3:0]  wait_cnt_reg, wait_cnt_next;
  logic        ack_reg, err_reg;
  logic [31:0] dat_reg;
  logic [15:0] fetch_cnt_reg;

  logic        req;
  logic        is_data;
  logic        enter_resp;

  logic [31:0] inst_head, ld_head;
  logic        inst_empty, ld_empty;
  logic        inst_pop, ld_pop;
  st_entry_t   st_in, st_head;
  logic        st_push_ready, st_full, st_empty, st_push;

  assign req     = i_wb_cyc && i_wb_stb;
  assign is_data = (i_wb_adr >= DATA_BASE);
  assign st_full = !st_push_ready;

  // --------------------------------------------------------------------------
  // Queues
  // --------------------------------------------------------------------------
  wb_resp_fifo #(.WIDTH(32), .DEPTH(DEPTH)) u_inst_q (
    .clk        (i_clk),
    .rst        (i_rst),
    .push_valid (i_inst_valid),
    .push_ready (o_inst_ready),
    .push_data  (i_inst_data),
    .pop_req    (inst_pop),
    .head_data  (inst_head),
    .empty      (inst_empty)
  );

  wb_resp_fifo #(.WIDTH(32), .DEPTH(DEPTH)) u_ld_q (
    .clk        (i_clk),
    .rst        (i_rst),
    .push_valid (i_ld_valid),
    .push_ready (o_ld_ready),
    .push_data  (i_ld_data),
    .pop_req    (ld_pop),
    .head_data  (ld_head),
    .empty      (ld_empty)
  );

  assign st_in = '{adr: i_wb_adr, sel: i_wb_sel, dat: i_wb_dat};

  wb_resp_fifo #(.WIDTH($bits(st_entry_t)), .DEPTH(DEPTH)) u_st_q (
    .clk        (i_clk),
    .rst        (i_rst),
    .push_valid (st_push),
    .push_ready (st_push_ready),
    .push_data  (st_in),
    .pop_req    (i_st_ready),
    .head_data  (st_head),
    .empty      (st_empty)
  );

  // --------------------------------------------------------------------------
  // FSM: next state. enter_resp marks the single cycle in which the queue side
  // effects of a cycle are applied (the transition into RESP).
  // --------------------------------------------------------------------------
  always_comb begin
    state_next    = state_reg;
    wait_cnt_next = wait_cnt_reg;
    enter_resp    = 1'b0;
    case (state_reg)
      IDLE: begin
        if (req) begin
          if (WAIT_CYCLES > 0) begin
            state_next    = WAIT;
            wait_cnt_next = WAIT_LOAD;
          end else if (i_wb_we && st_full) begin
            state_next = STALL;
          end else begin
            state_next = RESP;
            enter_resp = 1'b1;
          end
        end
      end
      WAIT: begin
        if (!i_wb_cyc) begin
          state_next = IDLE;
        end else if (wait_cnt_reg == 4'd0) begin
          if (i_wb_we && st_full) begin
            state_next = STALL;
          end else begin
            state_next = RESP;
            enter_resp = 1'b1;
          end
        end else begin
          wait_cnt_next = wait_cnt_reg - 4'd1;
        end
      end
      STALL: begin
        if (!i_wb_cyc) begin
          state_next = IDLE;
        end else if (!st_full) begin
          state_next = RESP;
          enter_resp = 1'b1;
        end
      end
      RESP:    state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  // Pops are requested unconditionally on entry; the FIFO ignores a pop on
  // empty, and the response logic below substitutes the default word.
  assign inst_pop = enter_resp && !i_wb_we && !is_data;
  assign ld_pop   = enter_resp && !i_wb_we &&  is_data;
  assign st_push  = enter_resp &&  i_wb_we;

  // --------------------------------------------------------------------------
  // State and registered response
  // --------------------------------------------------------------------------
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      state_reg     <= IDLE;
      wait_cnt_reg  <= 4'd0;
      ack_reg       <= 1'b0;
      err_reg       <= 1'b0;
      dat_reg       <= 32'd0;
      fetch_cnt_reg <= 16'd0;
    end else begin
      state_reg    <= state_next;
      wait_cnt_reg <= wait_cnt_next;
      ack_reg      <= 1'b0;
      err_reg      <= 1'b0;
      if (enter_resp) begin
        if (i_wb_we) begin
          ack_reg <= 1'b1;
        end else if (!is_data) begin
          ack_reg       <= 1'b1;
          dat_reg       <= inst_empty ? AMBER_NOP : inst_head;
          fetch_cnt_reg <= fetch_cnt_reg + 16'd1;
        end else if (!ld_empty) begin
          ack_reg <= 1'b1;
          dat_reg <= ld_head;
        end else begin
          dat_reg <= 32'd0;
          if (ERR_ON_EMPTY) err_reg <= 1'b1;
          else              ack_reg <= 1'b1;
        end
      end
    end
  end

  assign o_wb_ack    = ack_reg;
  assign o_wb_err    = err_reg;
  assign o_wb_dat    = dat_reg;
  assign o_fetch_cnt = fetch_cnt_reg;
  assign o_st_valid  = !st_empty;
  assign o_st_adr    = st_head.adr;
  assign o_st_sel    = st_head.sel;
  assign o_st_dat    = st_head.dat;

endmodule

// File: tb/tb_amber_wb_responder.sv
// ----------------------------------------------------------------------------
// tb_amber_wb_responder
// Three responders share one clock:
//   0: WAIT_CYCLES=0, ERR_ON_EMPTY=1
//   1: WAIT_CYCLES=3, ERR_ON_EMPTY=1
//   2: WAIT_CYCLES=2, ERR_ON_EMPTY=0
// ----------------------------------------------------------------------------
module tb_amber_wb_responder;

  logic clk;
  logic [2:0]       rst;
  logic [2:0][31:0] wb_adr;
  logic [2:0][3:0]  wb_sel;
  logic [2:0]       wb_we;
  logic [2:0][31:0] wb_wdat;
  logic [2:0]       wb_cyc;
  logic [2:0]       wb_stb;
  logic [2:0][31:0] wb_rdat;
  logic [2:0]       wb_ack;
  logic [2:0]       wb_err;
  logic [2:0]       inst_valid;
  logic [2:0]       inst_ready;
  logic [2:0][31:0] inst_data;
  logic [2:0]       ld_valid;
  logic [2:0]       ld_ready;
  logic [2:0][31:0] ld_data;
  logic [2:0]       st_valid;
  logic [2:0]       st_ready;
  logic [2:0][31:0] st_adr;
  logic [2:0][3:0]  st_sel;
  logic [2:0][31:0] st_dat;
  logic [2:0][15:0] fetch_cnt;

  int total = 0;
  int bad   = 0;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  for (genvar gi = 0; gi < 3; gi++) begin : g_dut
    amber_wb_responder #(
      .DEPTH        (16),
      .WAIT_CYCLES  ((gi == 0) ? 0 : ((gi == 1) ? 3 : 2)),
      .DATA_BASE    (32'h0000_8000),
      .ERR_ON_EMPTY ((gi == 2) ? 1'b0 : 1'b1)
    ) u_dut (
      .i_clk        (clk),
      .i_rst        (rst[gi]),
      .i_wb_adr     (wb_adr[gi]),
      .i_wb_sel     (wb_sel[gi]),
      .i_wb_we      (wb_we[gi]),
      .i_wb_dat     (wb_wdat[gi]),
      .i_wb_cyc     (wb_cyc[gi]),
      .i_wb_stb     (wb_stb[gi]),
      .o_wb_dat     (wb_rdat[gi]),
      .o_wb_ack     (wb_ack[gi]),
      .o_wb_err     (wb_err[gi]),
      .i_inst_valid (inst_valid[gi]),
      .o_inst_ready (inst_ready[gi]),
      .i_inst_data  (inst_data[gi]),
      .i_ld_valid   (ld_valid[gi]),
      .o_ld_ready   (ld_ready[gi]),
      .i_ld_data    (ld_data[gi]),
      .o_st_valid   (st_valid[gi]),
      .i_st_ready   (st_ready[gi]),
      .o_st_adr     (st_adr[gi]),
      .o_st_sel     (st_sel[gi]),
      .o_st_dat     (st_dat[gi]),
      .o_fetch_cnt  (fetch_cnt[gi])
    );
  end

  typedef struct {
    logic        we;
    logic [31:0] adr;
    logic [3:0]  sel;
    logic [31:0] wdat;
    logic        exp_err;
    logic        chk_dat;
    logic [31:0] exp_dat;
    logic [15:0] exp_fcnt;
  } vec_t;

  typedef struct {
    logic        err;
    logic        chk_dat;
    logic [31:0] dat;
    int          lat;
  } exp_t;

  exp_t sb[$];

  task automatic check(input string name, input logic [67:0] act, input logic [67:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h", name, act, exp);
    end
  endtask

  task automatic push_q(input int d, input bit to_ld, input logic [31:0] w);
    @(posedge clk); #1;
    if (to_ld) begin ld_valid[d] = 1'b1; ld_data[d] = w; end
    else       begin inst_valid[d] = 1'b1; inst_data[d] = w; end
    @(posedge clk); #1;
    ld_valid[d]   = 1'b0;
    inst_valid[d] = 1'b0;
  endtask

  // One Wishbone cycle; returns the response and the number of edges from
  // the request being sampled to ack/err, plus ack/err one cycle later.
  task automatic xfer(input int d, input logic we, input logic [31:0] adr,
                      input logic [3:0] sel, input logic [31:0] wdat,
                      output logic g_ack, output logic g_err, output logic [31:0] g_dat,
                      output int lat, output logic after);
    @(posedge clk); #1;
    wb_cyc[d] = 1'b1; wb_stb[d] = 1'b1; wb_we[d] = we;
    wb_adr[d] = adr;  wb_sel[d] = sel;  wb_wdat[d] = wdat;
    lat = 0; g_ack = 1'b0; g_err = 1'b0; g_dat = '0;
    while (lat < 50 && !(g_ack || g_err)) begin
      @(posedge clk); #1;
      lat++;
      g_ack = wb_ack[d]; g_err = wb_err[d]; g_dat = wb_rdat[d];
    end
    wb_cyc[d] = 1'b0; wb_stb[d] = 1'b0; wb_we[d] = 1'b0;
    @(posedge clk); #1;
    after = wb_ack[d] | wb_err[d];
  endtask

  task automatic run_txn(input int d, input logic we, input logic [31:0] adr,
                         input logic [3:0] sel, input logic [31:0] wdat,
                         input logic e_err, input logic e_chk, input logic [31:0] e_dat,
                         input int e_lat);
    exp_t e;
    logic g_ack, g_err, after;
    logic [31:0] g_dat;
    int lat;
    sb.push_back('{err: e_err, chk_dat: e_chk, dat: e_dat, lat: e_lat});
    xfer(d, we, adr, sel, wdat, g_ack, g_err, g_dat, lat, after);
    e = sb.pop_front();
    $display("txn dut%0d we=%0b adr=%h ack=%0b err=%0b dat=%h lat=%0d", d, we, adr, g_ack, g_err, g_dat, lat);
    check("ack", g_ack, !e.err);
    check("err", g_err, e.err);
    check("latency", lat, e.lat);
    if (e.chk_dat) check("rdata", g_dat, e.dat);
    check("single_cycle_resp", after, 1'b0);
  endtask

  initial begin
    vec_t vecs[7];
    logic saw;
    int n, prev, b2b;
    logic [67:0] first_head, last_head;
    logic [15:0] exp_fcnt0;

    rst = '1; wb_adr = '0; wb_sel = '0; wb_we = '0; wb_wdat = '0;
    wb_cyc = '0; wb_stb = '0; inst_valid = '0; inst_data = '0;
    ld_valid = '0; ld_data = '0; st_ready = '0;

    // fetch, fetch, empty fetch, read, empty read(err), write, boundary fetch
    vecs[0] = '{1'b0, 32'h0000_0000, 4'hF, 32'h0, 1'b0, 1'b1, 32'hE3A0_1005, 16'd1};
    vecs[1] = '{1'b0, 32'h0000_0004, 4'hF, 32'h0, 1'b0, 1'b1, 32'hE281_1001, 16'd2};
    vecs[2] = '{1'b0, 32'h0000_0008, 4'hF, 32'h0, 1'b0, 1'b1, 32'hE1A0_0000, 16'd3};
    vecs[3] = '{1'b0, 32'h0000_8000, 4'hF, 32'h0, 1'b0, 1'b1, 32'hCAFE_F00D, 16'd3};
    vecs[4] = '{1'b0, 32'h0000_8004, 4'hF, 32'h0, 1'b1, 1'b1, 32'h0000_0000, 16'd3};
    vecs[5] = '{1'b1, 32'h0000_8010, 4'h3, 32'hA5A5_0001, 1'b0, 1'b0, 32'h0, 16'd3};
    vecs[6] = '{1'b0, 32'h0000_7FFC, 4'hF, 32'h0, 1'b0, 1'b1, 32'hE1A0_0000, 16'd4};

    repeat (2) @(posedge clk);
    #1;
    check("rst_ack", wb_ack[0], 1'b0);
    check("rst_err", wb_err[0], 1'b0);
    check("rst_dat", wb_rdat[0], 32'h0);
    check("rst_fetch_cnt", fetch_cnt[0], 16'h0);
    check("rst_st_valid", st_valid[0], 1'b0);
    check("rst_inst_ready", inst_ready[0], 1'b1);
    check("rst_ld_ready", ld_ready[0], 1'b1);
    rst = '0;

    // ---------------- table-driven, zero wait states ----------------
    push_q(0, 1'b0, 32'hE3A0_1005);
    push_q(0, 1'b0, 32'hE281_1001);
    push_q(0, 1'b1, 32'hCAFE_F00D);
    for (int i = 0; i < 7; i++) begin
      run_txn(0, vecs[i].we, vecs[i].adr, vecs[i].sel, vecs[i].wdat,
              vecs[i].exp_err, vecs[i].chk_dat, vecs[i].exp_dat, 1);
      check("fetch_cnt", fetch_cnt[0], vecs[i].exp_fcnt);
    end
    exp_fcnt0 = 16'd4;
    check("st_head_valid", st_valid[0], 1'b1);
    check("st_head", {st_adr[0], st_sel[0], st_dat[0]}, {32'h0000_8010, 4'h3, 32'hA5A5_0001});

    // ---------------- wait states: read hit, then empty -> err ----------------
    push_q(1, 1'b1, 32'hDEAD_BEEF);
    run_txn(1, 1'b0, 32'h0000_8000, 4'hF, 32'h0, 1'b0, 1'b1, 32'hDEAD_BEEF, 4);
    run_txn(1, 1'b0, 32'h0000_8000, 4'hF, 32'h0, 1'b1, 1'b1, 32'h0, 4);

    // ---------------- store queue full -> stall ----------------
    st_ready[0] = 1'b1;
    n = 0;
    while (st_valid[0] && n < 40) begin @(posedge clk); #1; n++; end
    st_ready[0] = 1'b0;
    check("st_drained", st_valid[0], 1'b0);
    for (int i = 0; i < 16; i++)
      run_txn(0, 1'b1, 32'h0000_9000 + 32'(4 * i), 4'hF, 32'(i), 1'b0, 1'b0, 32'h0, 1);
    @(posedge clk); #1;
    wb_cyc[0] = 1'b1; wb_stb[0] = 1'b1; wb_we[0] = 1'b1;
    wb_adr[0] = 32'h0000_8010; wb_sel[0] = 4'hF; wb_wdat[0] = 32'h1234_5678;
    saw = 1'b0;
    repeat (5) begin @(posedge clk); #1; saw = saw | wb_ack[0] | wb_err[0]; end
    check("stall_holds_ack", saw, 1'b0);
    st_ready[0] = 1'b1;
    @(posedge clk); #1;
    st_ready[0] = 1'b0;
    n = 0;
    while (!wb_ack[0] && n < 10) begin @(posedge clk); #1; n++; end
    check("stall_release_ack", wb_ack[0], 1'b1);
    check("stall_release_lat", n, 1);
    wb_cyc[0] = 1'b0; wb_stb[0] = 1'b0; wb_we[0] = 1'b0;
    st_ready[0] = 1'b1;
    n = 0; first_head = '0; last_head = '0;
    while (st_valid[0] && n < 40) begin
      if (n == 0) first_head = {st_adr[0], st_sel[0], st_dat[0]};
      last_head = {st_adr[0], st_sel[0], st_dat[0]};
      n++;
      @(posedge clk); #1;
    end
    st_ready[0] = 1'b0;
    $display("txn dut0 store drain entries=%0d last=%h", n, last_head);
    check("st_drain_count", n, 16);
    check("st_first_entry", first_head, {32'h0000_9004, 4'hF, 32'h1});
    check("st_last_entry", last_head, {32'h0000_8010, 4'hF, 32'h1234_5678});

    // ---------------- abort during WAIT ----------------
    push_q(2, 1'b1, 32'h1111_1111);
    @(posedge clk); #1;
    wb_cyc[2] = 1'b1; wb_stb[2] = 1'b1; wb_adr[2] = 32'h0000_8000; wb_sel[2] = 4'hF;
    @(posedge clk); #1;
    wb_cyc[2] = 1'b0; wb_stb[2] = 1'b0;
    saw = 1'b0;
    repeat (5) begin @(posedge clk); #1; saw = saw | wb_ack[2] | wb_err[2]; end
    check("abort_no_resp", saw, 1'b0);
    run_txn(2, 1'b0, 32'h0000_8000, 4'hF, 32'h0, 1'b0, 1'b1, 32'h1111_1111, 3);
    run_txn(2, 1'b0, 32'h0000_8000, 4'hF, 32'h0, 1'b0, 1'b1, 32'h0, 3);

    // ---------------- reset during RESP ----------------
    run_txn(2, 1'b1, 32'h0000_8020, 4'h1, 32'h55, 1'b0, 1'b0, 32'h0, 3);
    push_q(2, 1'b0, 32'h3333_3333);
    push_q(2, 1'b1, 32'h2222_2222);
    push_q(2, 1'b1, 32'h2222_2223);
    @(posedge clk); #1;
    wb_cyc[2] = 1'b1; wb_stb[2] = 1'b1; wb_adr[2] = 32'h0000_8000;
    n = 0;
    while (!wb_ack[2] && n < 20) begin @(posedge clk); #1; n++; end
    check("pre_rst_ack", wb_ack[2], 1'b1);
    check("pre_rst_dat", wb_rdat[2], 32'h2222_2222);
    #1 rst[2] = 1'b1;
    #1;
    check("rst_drops_ack", wb_ack[2], 1'b0);
    check("rst_inst_ready", inst_ready[2], 1'b1);
    check("rst_ld_ready", ld_ready[2], 1'b1);
    check("rst_st_empty", st_valid[2], 1'b0);
    wb_cyc[2] = 1'b0; wb_stb[2] = 1'b0;
    @(posedge clk); #1;
    rst[2] = 1'b0;
    run_txn(2, 1'b0, 32'h0000_0000, 4'hF, 32'h0, 1'b0, 1'b1, 32'hE1A0_0000, 3);
    run_txn(2, 1'b0, 32'h0000_8000, 4'hF, 32'h0, 1'b0, 1'b1, 32'h0, 3);
    check("post_rst_fetch_cnt", fetch_cnt[2], 16'd1);

    // ---------------- fetch counter wrap ----------------
    @(posedge clk); #1;
    wb_cyc[0] = 1'b1; wb_stb[0] = 1'b1; wb_we[0] = 1'b0; wb_adr[0] = 32'h0000_0100;
    n = 0; prev = 0; b2b = 0;
    for (int c = 0; c < 140000; c++) begin
      @(posedge clk); #1;
      if (wb_ack[0] && prev != 0) b2b++;
      prev = int'(wb_ack[0]);
      if (wb_ack[0]) begin
        n++;
        if (32'(exp_fcnt0) + 32'(n) == 32'd65535) check("fetch_cnt_max", fetch_cnt[0], 16'hFFFF);
        if (32'(exp_fcnt0) + 32'(n) == 32'd65536) break;
      end
    end
    wb_cyc[0] = 1'b0; wb_stb[0] = 1'b0;
    $display("txn dut0 fetch stream count=%0d fetch_cnt=%h", n, fetch_cnt[0]);
    check("fetch_stream_count", n, 65536 - 32'(exp_fcnt0));
    check("fetch_cnt_wrap", fetch_cnt[0], 16'h0);
    check("no_back_to_back_ack", b2b, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
